// File: rtl/instr_encoder_if.sv
// Request handshake, IMEM write port and status bundle for the program loader.
// master = request source (loader driver), slave = instr_encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        req_kind;
  logic [3:0]        req_alu;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [12:0]       req_imm;
  logic              req_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_illegal;
  logic              overflow;
  logic              done;
  logic [ADDR_W:0]   words_written;

  modport master (
    output start, base_addr, req_valid, req_kind, req_alu, req_rd, req_rs1,
           req_rs2, req_imm, req_last,
    input  req_ready, imem_we, imem_addr, imem_wdata, err_illegal, overflow,
           done, words_written
  );

  modport slave (
    input  start, base_addr, req_valid, req_kind, req_alu, req_rd, req_rs1,
           req_rs2, req_imm, req_last,
    output req_ready, imem_we, imem_addr, imem_wdata, err_illegal, overflow,
           done, words_written
  );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic micro-op requests into RV32I words and
// writes them to consecutive IMEM addresses, one word per cycle.
module instr_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU control codes as produced by the ALU control decode
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAST,
    S_FULL
  } state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] enc_word_c;
  logic        enc_legal_c;
  logic [2:0]  f3_c;
  logic [6:0]  f7_c;
  logic        alu_known_c;
  logic        accept_c;
  logic        at_end_c;

  // Field encoding and legality of the request currently on the bus
  always_comb begin
    enc_word_c  = '0;
    enc_legal_c = 1'b0;
    f3_c        = 3'b000;
    f7_c        = 7'b0000000;
    alu_known_c = 1'b1;

    case (bus.req_alu)
      ALU_ADD: f3_c = 3'b000;
      ALU_SUB: begin
        f3_c = 3'b000;
        f7_c = 7'b0100000;
      end
      ALU_XOR: f3_c = 3'b100;
      ALU_OR:  f3_c = 3'b110;
      ALU_AND: f3_c = 3'b111;
      default: alu_known_c = 1'b0;
    endcase

    case (bus.req_kind)
      OP_R: begin
        enc_legal_c = alu_known_c;
        enc_word_c  = {f7_c, bus.req_rs2, bus.req_rs1, f3_c, bus.req_rd, OP_R};
      end
      OP_I: begin
        enc_legal_c = alu_known_c && (bus.req_alu != ALU_SUB);
        enc_word_c  = {bus.req_imm[11:0], bus.req_rs1, f3_c, bus.req_rd, OP_I};
      end
      OP_LW: begin
        enc_legal_c = (bus.req_alu == ALU_ADD);
        enc_word_c  = {bus.req_imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, OP_LW};
      end
      OP_SW: begin
        enc_legal_c = (bus.req_alu == ALU_ADD);
        enc_word_c  = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010,
                       bus.req_imm[4:0], OP_SW};
      end
      OP_BEQ: begin
        enc_legal_c = (bus.req_alu == ALU_SUB) && !bus.req_imm[0];
        enc_word_c  = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                       3'b000, bus.req_imm[4:1], bus.req_imm[11], OP_BEQ};
      end
      default: enc_legal_c = 1'b0;
    endcase
  end

  // Slot reserved at accept time, so the full condition is known before the write
  assign accept_c = ready_q && bus.req_valid;
  assign at_end_c = (addr_q == ADDR_W'(DEPTH - 1)) || (addr_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          addr_d  = bus.base_addr;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          if (enc_legal_c) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = enc_word_c;
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
          if (bus.req_last) begin
            state_d = S_LAST;
          end else if (enc_legal_c && at_end_c) begin
            state_d = S_FULL;
            ovf_d   = 1'b1;
          end
        end
      end
      S_LAST: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_FULL: begin
        if (bus.start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.imem_we       = we_q;
  assign bus.imem_addr     = waddr_q;
  assign bus.imem_wdata    = wdata_q;
  assign bus.err_illegal   = err_q;
  assign bus.overflow      = ovf_q;
  assign bus.done          = done_q;
  assign bus.words_written = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded bench for instr_encoder: a 1024-word loader and a 4-word loader
// share stimulus fields; per-instance monitors pop expected writes/errors.
module tb_instr_encoder;

  localparam logic [6:0] K_R   = 7'b0110011;
  localparam logic [6:0] K_I   = 7'b0010011;
  localparam logic [6:0] K_LW  = 7'b0000011;
  localparam logic [6:0] K_SW  = 7'b0100011;
  localparam logic [6:0] K_BEQ = 7'b1100011;
  localparam logic [6:0] K_BAD = 7'b1111111;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_XOR = 4'b0011;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_BAD = 4'b1111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  kind = '0;
  logic [3:0]  alu = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [12:0] imm = '0;
  logic        last = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic [9:0]  base = '0;

  instr_encoder_if #(.ADDR_W(10)) bus_a ();
  instr_encoder_if #(.ADDR_W(2))  bus_b ();

  assign bus_a.start = start_a;     assign bus_b.start = start_b;
  assign bus_a.base_addr = base;    assign bus_b.base_addr = base[1:0];
  assign bus_a.req_valid = valid_a; assign bus_b.req_valid = valid_b;
  assign bus_a.req_kind = kind;     assign bus_b.req_kind = kind;
  assign bus_a.req_alu = alu;       assign bus_b.req_alu = alu;
  assign bus_a.req_rd = rd;         assign bus_b.req_rd = rd;
  assign bus_a.req_rs1 = rs1;       assign bus_b.req_rs1 = rs1;
  assign bus_a.req_rs2 = rs2;       assign bus_b.req_rs2 = rs2;
  assign bus_a.req_imm = imm;       assign bus_b.req_imm = imm;
  assign bus_a.req_last = last;     assign bus_b.req_last = last;

  instr_encoder #(.ADDR_W(10), .DEPTH(1024)) u_big   (.clk(clk), .rst(rst), .bus(bus_a));
  instr_encoder #(.ADDR_W(2),  .DEPTH(4))    u_small (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    bit          illegal;
    int          addr;
    logic [31:0] word;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   exp_addr_a = 0;
  int   exp_addr_b = 0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference encoder: places each field by shifting into its RV32I bit position.
  function automatic logic [32:0] ref_encode(input logic [6:0] k, input logic [3:0] a,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [12:0] im);
    int unsigned f3, f7, iv, w;
    bit known, ok;
    known = 1'b1; f3 = 0; f7 = 0; ok = 1'b0; w = 0;
    iv = int'(im);
    case (a)
      A_ADD: f3 = 0;
      A_SUB: f7 = 32;
      A_XOR: f3 = 4;
      A_OR:  f3 = 6;
      A_AND: f3 = 7;
      default: known = 1'b0;
    endcase
    if (k == K_R) begin
      ok = known;
      w  = (f7 << 25) | (int'(s2) << 20) | (int'(s1) << 15) | (f3 << 12) | (int'(d) << 7) | 32'h33;
    end else if (k == K_I) begin
      ok = known && (a != A_SUB);
      w  = ((iv & 32'hFFF) << 20) | (int'(s1) << 15) | (f3 << 12) | (int'(d) << 7) | 32'h13;
    end else if (k == K_LW) begin
      ok = (a == A_ADD);
      w  = ((iv & 32'hFFF) << 20) | (int'(s1) << 15) | (2 << 12) | (int'(d) << 7) | 32'h03;
    end else if (k == K_SW) begin
      ok = (a == A_ADD);
      w  = (((iv >> 5) & 127) << 25) | (int'(s2) << 20) | (int'(s1) << 15) | (2 << 12)
         | ((iv & 31) << 7) | 32'h23;
    end else if (k == K_BEQ) begin
      ok = (a == A_SUB) && ((iv % 2) == 0);
      w  = (((iv >> 12) & 1) << 31) | (((iv >> 5) & 63) << 25) | (int'(s2) << 20)
         | (int'(s1) << 15) | (((iv >> 1) & 15) << 8) | (((iv >> 11) & 1) << 7) | 32'h63;
    end
    return {ok, w[31:0]};
  endfunction

  task automatic score(input string tag, input exp_t e, input logic we, input logic err,
                       input int addr, input logic [31:0] data);
    chk({tag, "_event"}, {30'd0, err, we}, e.illegal ? 32'd2 : 32'd1);
    chk({tag, "_latency"}, cyc, e.cyc + 1);
    if (!e.illegal) begin
      chk({tag, "_addr"}, addr, e.addr);
      chk({tag, "_wdata"}, data, e.word);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (bus_a.imem_we === 1'b1 || bus_a.err_illegal === 1'b1) begin
      if (q_a.size() == 0) chk("a_unexpected_event", 1, 0);
      else begin
        e = q_a.pop_front();
        score("a", e, bus_a.imem_we, bus_a.err_illegal, int'(bus_a.imem_addr), bus_a.imem_wdata);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (bus_b.imem_we === 1'b1 || bus_b.err_illegal === 1'b1) begin
      if (q_b.size() == 0) chk("b_unexpected_event", 1, 0);
      else begin
        e = q_b.pop_front();
        score("b", e, bus_b.imem_we, bus_b.err_illegal, int'(bus_b.imem_addr), bus_b.imem_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit sel, input int b);
    base = 10'(b);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    if (sel) exp_addr_b = b % 4; else exp_addr_a = b % 1024;
  endtask

  // Presents one request and waits (bounded) for acceptance; queues the expectation.
  task automatic send(input bit sel, input logic [6:0] k, input logic [3:0] a,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [12:0] im, input bit lst, input bit ovr,
                      input logic [31:0] ovr_word, input int budget, output bit acc);
    exp_t e;
    logic [32:0] r;
    int t;
    kind = k; alu = a; rd = d; rs1 = s1; rs2 = s2; imm = im; last = lst;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    acc = 1'b0;
    t = 0;
    e.cyc = 0;
    while (!acc && t < budget) begin
      @(negedge clk);
      t++;
      if ((sel ? bus_b.req_ready : bus_a.req_ready) === 1'b1) begin
        acc = 1'b1;
        e.cyc = cyc;
      end
    end
    if (acc) begin
      step();
      r = ref_encode(k, a, d, s1, s2, im);
      e.illegal = !r[32];
      e.word = ovr ? ovr_word : r[31:0];
      if (sel) begin
        e.addr = exp_addr_b;
        if (!e.illegal) exp_addr_b = (exp_addr_b + 1) % 4;
        q_b.push_back(e);
      end else begin
        e.addr = exp_addr_a;
        if (!e.illegal) exp_addr_a = (exp_addr_a + 1) % 1024;
        q_a.push_back(e);
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    last = 1'b0;
  endtask

  // Called right after a last request is accepted.
  task automatic wait_done(input bit sel, input int exp_words);
    chk("done_early", sel ? bus_b.done : bus_a.done, 0);
    step();
    chk("done_pulse", sel ? bus_b.done : bus_a.done, 1);
    chk("done_words", sel ? 32'(bus_b.words_written) : 32'(bus_a.words_written), exp_words);
    step();
    chk("done_clear", sel ? bus_b.done : bus_a.done, 0);
    chk("idle_ready", sel ? bus_b.req_ready : bus_a.req_ready, 0);
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_we"}, bus_a.imem_we, 0);
    chk({tag, "_err"}, bus_a.err_illegal, 0);
    chk({tag, "_ovf"}, bus_a.overflow, 0);
    chk({tag, "_done"}, bus_a.done, 0);
    chk({tag, "_ready"}, bus_a.req_ready, 0);
    chk({tag, "_addr"}, 32'(bus_a.imem_addr), 0);
    chk({tag, "_wdata"}, bus_a.imem_wdata, 0);
    chk({tag, "_words"}, 32'(bus_a.words_written), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bit acc;
    int legal_cnt;
    logic [6:0]  k;
    logic [3:0]  a;
    logic [12:0] im;
    logic [32:0] r;
    logic [6:0] kinds[6];
    logic [3:0] alus[6];
    kinds = '{K_R, K_I, K_LW, K_SW, K_BEQ, K_BAD};
    alus  = '{A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_BAD};

    rst = 1'b0;
    repeat (3) step();
    check_zero_a("reset");
    rst = 1'b1;
    step();

    // Load 1: back-to-back R/R/LW/SW then BEQ last
    do_start(0, 0);
    send(0, K_R,  A_ADD, 5'd3, 5'd1, 5'd2, 13'd0,  0, 1, 32'h002081B3, 20, acc); chk("acc_add", acc, 1);
    send(0, K_R,  A_SUB, 5'd5, 5'd6, 5'd7, 13'd0,  0, 1, 32'h407302B3, 20, acc); chk("acc_sub", acc, 1);
    send(0, K_LW, A_ADD, 5'd4, 5'd2, 5'd0, 13'd8,  0, 1, 32'h00812203, 20, acc); chk("acc_lw", acc, 1);
    send(0, K_SW, A_ADD, 5'd0, 5'd2, 5'd5, 13'd12, 0, 1, 32'h00512623, 20, acc); chk("acc_sw", acc, 1);
    send(0, K_BEQ, A_SUB, 5'd0, 5'd1, 5'd2, 13'd16, 1, 1, 32'h00208863, 20, acc); chk("acc_beq", acc, 1);
    wait_done(0, 5);

    // Load 2: I-type ADD with sign-extending immediate bits
    do_start(0, 16);
    send(0, K_I, A_ADD, 5'd1, 5'd0, 5'd0, 13'h1FFF, 1, 1, 32'hFFF00093, 20, acc); chk("acc_i", acc, 1);
    wait_done(0, 1);

    // Load 3: illegal requests leave address and count untouched
    do_start(0, 32);
    send(0, K_I,   A_SUB, 5'd1, 5'd2, 5'd3, 13'd5, 0, 0, 32'h0, 20, acc);
    send(0, K_BEQ, A_SUB, 5'd0, 5'd1, 5'd2, 13'd3, 0, 0, 32'h0, 20, acc);
    send(0, K_LW,  A_XOR, 5'd4, 5'd2, 5'd0, 13'd8, 0, 0, 32'h0, 20, acc);
    step();
    chk("illegal_words", 32'(bus_a.words_written), 0);
    chk("illegal_no_we", bus_a.imem_we, 0);
    send(0, K_R, A_AND, 5'd9, 5'd10, 5'd11, 13'd0, 1, 0, 32'h0, 20, acc); chk("acc_after_ill", acc, 1);
    wait_done(0, 1);

    // Reset asserted during a RUN write cycle
    do_start(0, 48);
    send(0, K_R, A_OR, 5'd1, 5'd2, 5'd3, 13'd0, 0, 0, 32'h0, 20, acc);
    chk("rst_write_live", bus_a.imem_we, 1);
    rst = 1'b0;
    step();
    check_zero_a("midrst");
    rst = 1'b1;
    do_start(0, 80);
    send(0, K_R, A_XOR, 5'd7, 5'd8, 5'd9, 13'd0, 1, 0, 32'h0, 20, acc); chk("acc_resume", acc, 1);
    wait_done(0, 1);

    // Overflow on the 4-word instance
    do_start(1, 2);
    send(1, K_R, A_ADD, 5'd1, 5'd1, 5'd1, 13'd0, 0, 0, 32'h0, 8, acc); chk("ovf_acc1", acc, 1);
    send(1, K_R, A_ADD, 5'd2, 5'd2, 5'd2, 13'd0, 0, 0, 32'h0, 8, acc); chk("ovf_acc2", acc, 1);
    send(1, K_R, A_ADD, 5'd3, 5'd3, 5'd3, 13'd0, 0, 0, 32'h0, 8, acc); chk("ovf_acc3_refused", acc, 0);
    chk("ovf_flag", bus_b.overflow, 1);
    chk("ovf_ready", bus_b.req_ready, 0);
    chk("ovf_words", 32'(bus_b.words_written), 2);
    do_start(1, 0);
    chk("full_to_idle_ready", bus_b.req_ready, 0);
    chk("full_to_idle_ovf", bus_b.overflow, 1);
    do_start(1, 0);
    chk("restart_ovf_clear", bus_b.overflow, 0);
    send(1, K_R, A_SUB, 5'd4, 5'd5, 5'd6, 13'd0, 1, 0, 32'h0, 8, acc); chk("b_acc_last", acc, 1);
    wait_done(1, 1);

    // Randomized load with occasional gaps and illegal requests
    do_start(0, int'($urandom_range(100, 400)));
    legal_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      k  = kinds[$urandom_range(0, 5)];
      a  = alus[$urandom_range(0, 5)];
      im = 13'($urandom);
      if ((k == K_LW || k == K_SW) && $urandom_range(0, 1) == 1) a = A_ADD;
      if (k == K_BEQ && $urandom_range(0, 1) == 1) begin
        a = A_SUB;
        im[0] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
      r = ref_encode(k, a, 5'($urandom), 5'($urandom), 5'($urandom), im);
      send(0, k, a, 5'($urandom), 5'($urandom), 5'($urandom), im, i == 59, 0, 32'h0, 20, acc);
      if (!acc) chk("rand_accept", acc, 1);
      if (ref_encode(kind, alu, rd, rs1, rs2, imm) !== 33'h0 && k == kind) begin
        r = ref_encode(k, a, rd, rs1, rs2, im);
        if (r[32]) legal_cnt++;
      end
    end
    wait_done(0, legal_cnt);

    repeat (3) step();
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
